// File: rtl/apb_i2c_bridge.sv
// rtl/apb_i2c_bridge.sv - APB slave that turns each access into one I2C master memory command
// Bound with a WAIT-state timeout; a dropped psel abandons the transfer without pready.
module apb_i2c_bridge #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              i2c_ce,
  output logic              i2c_wren,
  output logic              i2c_rden,
  output logic [7:0]        i2c_addr,
  output logic [7:0]        i2c_wdata,
  input  logic [7:0]        i2c_rdata,
  input  logic              i2c_ready,
  input  logic              i2c_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             addr_ok;

  generate
    if (ADDR_W > 8) begin : g_addr_chk
      assign addr_ok = (paddr[ADDR_W-1:8] == '0);
    end else begin : g_addr_all
      assign addr_ok = 1'b1;
    end
  endgenerate

  assign i2c_addr  = addr_q;
  assign i2c_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    pready   = 1'b0;
    prdata   = 8'h00;
    pslverr  = 1'b0;
    i2c_ce   = 1'b0;
    i2c_wren = 1'b0;
    i2c_rden = 1'b0;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          write_d = pwrite;
          addr_d  = paddr[7:0];
          wdata_d = pwdata;
          rdata_d = 8'h00;
          cnt_d   = '0;
          // Out-of-window addresses never reach the I2C master.
          if (addr_ok) begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        i2c_ce   = 1'b1;
        i2c_wren = write_q;
        i2c_rden = !write_q;
        state_d  = psel ? WAIT : IDLE;
      end
      WAIT: begin
        i2c_ce = 1'b1;
        if (!psel) begin
          state_d = IDLE;
        end else if (i2c_ready) begin
          rdata_d = write_q ? 8'h00 : i2c_rdata;
          err_d   = i2c_error;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          pready  = 1'b1;
          prdata  = rdata_q;
          pslverr = err_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_i2c_bridge.sv
// tb/tb_apb_i2c_bridge.sv - self-checking bench for apb_i2c_bridge
// Transfer-level model: completion cycle, response and I2C activity derived per transfer.
module tb_apb_i2c_bridge;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [7:0]  pwdata, prdata;
  logic        pready, pslverr;
  logic        i2c_ce, i2c_wren, i2c_rden;
  logic [7:0]  i2c_addr, i2c_wdata, i2c_rdata;
  logic        i2c_ready, i2c_error;

  int checks   = 0;
  int failures = 0;

  apb_i2c_bridge #(.TIMEOUT_CYCLES(T), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .i2c_ce(i2c_ce), .i2c_wren(i2c_wren), .i2c_rden(i2c_rden), .i2c_addr(i2c_addr),
    .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata), .i2c_ready(i2c_ready), .i2c_error(i2c_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle index (0 = setup) on which pready is expected for a transfer.
  function automatic int exp_done(input bit bad, input int rdy_c);
    if (bad) return 1;
    if (rdy_c >= 2 && rdy_c <= T + 1) return rdy_c + 1;
    return T + 2;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; i2c_ready = 1'b0;
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".pready"}, pready, 0);
    chk({tag, ".ce"}, i2c_ce, 0);
    chk({tag, ".wren"}, i2c_wren, 0);
    chk({tag, ".rden"}, i2c_rden, 0);
    chk({tag, ".prdata"}, prdata, 0);
    chk({tag, ".pslverr"}, pslverr, 0);
  endtask

  // rdy_c: cycle index (1 = ISSUE) at which i2c_ready is pulsed.
  task automatic xfer(input string tag, input bit w, input logic [15:0] a, input logic [7:0] d,
                      input int rdy_c, input logic [7:0] r, input bit e);
    bit         bad, timed_out, zero_ok;
    int         exp_c, seen_c, n_wr, n_rd, n_ce;
    logic [7:0] got_prdata, a_iss, d_iss, exp_prdata;
    logic       got_err, exp_err;
    bad       = (a[15:8] != 8'h00);
    exp_c     = exp_done(bad, rdy_c);
    timed_out = !bad && !(rdy_c >= 2 && rdy_c <= T + 1);
    exp_err    = (bad || timed_out) ? 1'b1 : e;
    exp_prdata = (bad || timed_out || w) ? 8'h00 : r;
    seen_c = -1; n_wr = 0; n_rd = 0; n_ce = 0; zero_ok = 1'b1;
    got_prdata = 8'h00; got_err = 1'b0; a_iss = 8'h00; d_iss = 8'h00;
    for (int c = 0; c < 40 && seen_c < 0; c++) begin
      @(posedge clk); #1;
      psel = 1'b1; penable = (c != 0); pwrite = w; paddr = a; pwdata = d;
      i2c_ready = (c == rdy_c);
      i2c_rdata = (c == rdy_c) ? r : 8'($urandom);
      i2c_error = (c == rdy_c) ? e : 1'($urandom);
      @(negedge clk);
      if (i2c_wren) n_wr++;
      if (i2c_rden) n_rd++;
      if (i2c_ce)   n_ce++;
      if (c == 1) begin a_iss = i2c_addr; d_iss = i2c_wdata; end
      if (pready) begin
        seen_c = c; got_prdata = prdata; got_err = pslverr;
      end else if (prdata !== 8'h00 || pslverr !== 1'b0) begin
        zero_ok = 1'b0;
      end
    end
    chk({tag, ".latency"}, seen_c, exp_c);
    chk({tag, ".pslverr"}, got_err, exp_err);
    chk({tag, ".prdata"}, got_prdata, exp_prdata);
    chk({tag, ".wren_cnt"}, n_wr, (!bad && w) ? 1 : 0);
    chk({tag, ".rden_cnt"}, n_rd, (!bad && !w) ? 1 : 0);
    chk({tag, ".ce_cycles"}, n_ce, bad ? 0 : exp_c - 1);
    chk({tag, ".quiet_when_not_ready"}, zero_ok, 1);
    if (!bad) begin
      chk({tag, ".i2c_addr"}, a_iss, a[7:0]);
      chk({tag, ".i2c_wdata"}, d_iss, d);
    end
  endtask

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0;
    pwdata = 8'h0; i2c_rdata = 8'h0; i2c_ready = 1'b0; i2c_error = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    chk("reset.i2c_addr", i2c_addr, 0);
    chk("reset.i2c_wdata", i2c_wdata, 0);
    @(posedge clk); #1; reset = 1'b0;

    xfer("write", 1'b1, 16'h0012, 8'hA5, 4, 8'h00, 1'b0);
    idle(1);
    xfer("read", 1'b0, 16'h0040, 8'h00, 3, 8'h3C, 1'b0);
    idle(2);
    xfer("nack_minlat", 1'b0, 16'h0041, 8'h11, 2, 8'h99, 1'b1);
    idle(1);
    xfer("timeout", 1'b0, 16'h0042, 8'h00, 99, 8'h55, 1'b0);
    idle(1);
    xfer("ready_in_issue", 1'b1, 16'h0043, 8'h22, 1, 8'h55, 1'b0);
    idle(1);
    xfer("last_wait", 1'b0, 16'h0044, 8'h00, T + 1, 8'hC3, 1'b0);
    xfer("after_last", 1'b0, 16'h0045, 8'h00, T + 2, 8'hC3, 1'b0);
    idle(1);
    xfer("bad_addr_wr", 1'b1, 16'h0100, 8'h5A, 3, 8'h00, 1'b0);
    xfer("bad_addr_rd", 1'b0, 16'h8000, 8'h00, 3, 8'h77, 1'b0);
    xfer("b2b_a", 1'b1, 16'h0010, 8'h01, 2, 8'h00, 1'b0);
    xfer("b2b_b", 1'b0, 16'h0011, 8'h02, 2, 8'hE7, 1'b0);

    // psel dropped mid-WAIT, then a late i2c_ready
    @(posedge clk); #1; psel = 1; penable = 0; pwrite = 0; paddr = 16'h0040;
    @(posedge clk); #1; penable = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; psel = 0; penable = 0;
    @(negedge clk);
    chk("drop.ce_before", i2c_ce, 1);
    @(posedge clk); #1; i2c_ready = 1; i2c_rdata = 8'hEE; i2c_error = 1;
    @(negedge clk);
    check_quiet("drop.late_ready");
    @(posedge clk); #1; i2c_ready = 0;
    @(negedge clk);
    check_quiet("drop.after");
    xfer("drop.next", 1'b0, 16'h0030, 8'h00, 5, 8'h4B, 1'b0);
    idle(1);

    // reset mid-WAIT, then a stale i2c_ready
    @(posedge clk); #1; psel = 1; penable = 0; pwrite = 1; paddr = 16'h0055; pwdata = 8'h77;
    @(posedge clk); #1; penable = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0; psel = 0; penable = 0;
    i2c_ready = 1; i2c_rdata = 8'hFF; i2c_error = 1;
    @(negedge clk);
    check_quiet("rst_abort");
    chk("rst_abort.i2c_addr", i2c_addr, 0);
    chk("rst_abort.i2c_wdata", i2c_wdata, 0);
    @(posedge clk); #1; i2c_ready = 0;
    @(negedge clk);
    check_quiet("rst_abort.after");
    xfer("rst_abort.next", 1'b1, 16'h0001, 8'h3D, 3, 8'h00, 1'b0);

    for (int i = 0; i < 24; i++) begin
      bit         w, e;
      logic [15:0] a;
      w = 1'($urandom);
      e = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(1, 255) << 8) : 16'($urandom_range(0, 255));
      xfer($sformatf("rnd%0d", i), w, a, 8'($urandom), int'($urandom_range(0, 20)), 8'($urandom), e);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/apb_i2c_bridge.md
APB_I2C_BRIDGE -- requirements
Module: apb_i2c_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum WAIT-state cycles before a transfer is aborted with error.
REQ-002 SHALL have parameter ADDR_W, default 16: APB address width; bits above [7:0] must be zero for a valid access.
REQ-003 clk  input  1  single clock for all logic; one clock domain, shared with the I2C master.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 psel  input  1  APB select.
REQ-006 penable  input  1  APB access phase.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  ADDR_W  APB address; [7:0] is the I2C memory address.
REQ-009 pwdata  input  8  APB write data.
REQ-010 prdata  output  8  APB read data.
REQ-011 pready  output  1  APB transfer complete.
REQ-012 pslverr  output  1  APB transfer error.
REQ-013 i2c_ce  output  1  I2C master command enable; high for the whole command.
REQ-014 i2c_wren  output  1  one-cycle write-command strobe.
REQ-015 i2c_rden  output  1  one-cycle read-command strobe.
REQ-016 i2c_addr  output  8  I2C memory address.
REQ-017 i2c_wdata  output  8  I2C write data.
REQ-018 i2c_rdata  input  8  read data from the I2C master.
REQ-019 i2c_ready  input  1  I2C master completion, one-cycle pulse.
REQ-020 i2c_error  input  1  I2C master NACK/error; valid when i2c_ready = 1.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, WAIT, DONE.
REQ-022 In IDLE, when psel=1 and penable=0, the block SHALL latch pwrite, paddr and pwdata and go to ISSUE.
- Exception: if paddr[ADDR_W-1:8] != 0, it SHALL go directly to DONE with the error flag set and issue no I2C command.
REQ-023 In ISSUE, the block SHALL drive i2c_ce=1 and pulse exactly one of i2c_wren or i2c_rden (per the latched pwrite) for one cycle, then go to WAIT.
REQ-024 i2c_addr and i2c_wdata SHALL present the latched values, held stable from ISSUE through WAIT.
REQ-025 In WAIT, i2c_ce SHALL stay 1, and a timeout counter SHALL increment each cycle.
- On i2c_ready=1: capture i2c_rdata (reads only) and i2c_error, then go to DONE.
REQ-026 If the counter reaches TIMEOUT_CYCLES-1 with no i2c_ready, the block SHALL go to DONE with pslverr=1 and prdata=0x00.
REQ-027 i2c_ready asserted during ISSUE SHALL be ignored; i2c_ready SHALL be sampled only in WAIT.
REQ-028 In DONE, while psel=1 and penable=1, the block SHALL:
- assert pready=1 for exactly one cycle;
- drive prdata (captured data for reads, 0x00 for writes) and pslverr;
- then return to IDLE.
REQ-029 pready SHALL be 0 in every state other than DONE.
- prdata and pslverr SHALL be 0 whenever pready=0.
REQ-030 i2c_ce SHALL drop to 0 on entry to DONE.
REQ-031 If psel drops in ISSUE, WAIT or DONE, the block SHALL return to IDLE next cycle.
- i2c_ce, i2c_wren and i2c_rden SHALL go to 0, with no pready and no retry.
- A late i2c_ready SHALL be ignored in IDLE.
REQ-032 Minimum latency SHALL be: setup cycle T0, ISSUE T1, WAIT T2 (i2c_ready at T2), pready at T3.
REQ-033 Back-to-back transfers SHALL be accepted: a new setup phase seen in IDLE on the cycle after DONE starts the next transfer.
REQ-034 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide, SHALL clear on entry to ISSUE, and SHALL never wrap.

Reset
REQ-035 On reset=1 at a clk edge, the block SHALL enter IDLE and clear all outputs and internal registers to 0, overriding any in-progress transfer.
REQ-036 After reset, the first transfer SHALL behave as if no prior transfer occurred; an i2c_ready arriving after reset SHALL be ignored.

Verification
REQ-037 Write: paddr=0x0012, pwdata=0xA5, i2c_ready pulsed 3 cycles after ISSUE -> one i2c_wren pulse, i2c_addr=0x12, i2c_wdata=0xA5, pready one cycle, pslverr=0.
REQ-038 Read: paddr=0x0040, i2c_ready with i2c_rdata=0x3C and i2c_error=0 -> one i2c_rden pulse, prdata=0x3C with pready, pslverr=0.
REQ-039 NACK: read with i2c_error=1 at i2c_ready -> pready=1, pslverr=1.
REQ-040 Timeout, with TIMEOUT_CYCLES=16 and i2c_ready never asserted -> pready and pslverr=1 exactly 16 WAIT cycles after ISSUE, prdata=0x00, i2c_ce=0.
REQ-041 Bad address: paddr=0x0100 -> no i2c_ce/i2c_wren/i2c_rden activity, pready and pslverr=1 on the first access-phase cycle.
REQ-042 Abort: reset asserted mid-WAIT, then i2c_ready pulsed -> all outputs 0, state IDLE, no pready; next write to 0x0001 completes normally.
